// File: rtl/sqrt_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg
// Shared constants and the controller state encoding for the square-root job
// controller slice.
//   CYC_W            width of the WAIT-cycle counter and of out_cycles_o
//   DEFAULT_DATA_W   default operand width
//   DEFAULT_TIMEOUT  default WAIT-cycle limit per job
//   state_e          Gray-coded controller states
// -----------------------------------------------------------------------------
package sqrt_pkg;

    localparam int CYC_W           = 8;
    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_TIMEOUT = 255;

    // Gray sequence: every legal transition (IDLE->LAUNCH->WAIT->STORE->IDLE)
    // flips exactly one state bit.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_WAIT   = 2'b11,
        ST_STORE  = 2'b10
    } state_e;

endpackage

// File: rtl/sqrt_job_controller_if.sv
// -----------------------------------------------------------------------------
// sqrt_job_controller_if
// Bundles every non-clock signal of sqrt_job_controller.
//   slave  modport : the controller side (drives in_ready_o, core_*_o, out_*_o)
//   master modport : the environment side (operand producer, core, consumer)
// Signals:
//   in_valid_i / in_ready_o / in_data_i        operand handshake
//   core_start_o / core_operand_o              launch of the square-root core
//   core_done_i / core_root_i                  core result pulse
//   out_valid_o / out_ready_i / out_root_o /
//   out_err_o / out_cycles_o                   result FIFO head
//   busy_o                                     controller not idle
// -----------------------------------------------------------------------------
interface sqrt_job_controller_if #(
    parameter int DATA_W = sqrt_pkg::DEFAULT_DATA_W
);
    localparam int ROOT_W = DATA_W / 2;

    logic                       in_valid_i;
    logic                       in_ready_o;
    logic [DATA_W-1:0]          in_data_i;
    logic                       core_start_o;
    logic [DATA_W-1:0]          core_operand_o;
    logic                       core_done_i;
    logic [ROOT_W-1:0]          core_root_i;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [ROOT_W-1:0]          out_root_o;
    logic                       out_err_o;
    logic [sqrt_pkg::CYC_W-1:0] out_cycles_o;
    logic                       busy_o;

    modport slave (
        input  in_valid_i, in_data_i, core_done_i, core_root_i, out_ready_i,
        output in_ready_o, core_start_o, core_operand_o, out_valid_o,
               out_root_o, out_err_o, out_cycles_o, busy_o
    );

    modport master (
        output in_valid_i, in_data_i, core_done_i, core_root_i, out_ready_i,
        input  in_ready_o, core_start_o, core_operand_o, out_valid_o,
               out_root_o, out_err_o, out_cycles_o, busy_o
    );

endinterface

// File: rtl/sqrt_result_fifo.sv
// -----------------------------------------------------------------------------
// sqrt_result_fifo
// Two-entry first-in first-out result buffer.
//   clk, rst       clock and synchronous active-high reset
//   push_i         write push_data_i (ignored when full)
//   push_data_i    entry to store
//   pop_i          drop the head entry (ignored when empty)
//   head_o         head entry, forced to 0 while empty
//   full_o         two entries held
//   empty_o        no entry held
//   count_o        number of entries held (0..2)
// -----------------------------------------------------------------------------
module sqrt_result_fifo #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    localparam int DEPTH = 2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // Push and pop together leave the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; an entry is only observable after it has
    // been written, and head_o is forced to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sqrt_job_controller.sv
// -----------------------------------------------------------------------------
// sqrt_job_controller
// Accepts one operand at a time, launches an external square-root core, waits
// for its done pulse (or a WAIT-cycle timeout) and queues {root, err, cycles}
// in a two-entry result FIFO.
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset; abandons any job, empties the FIFO
//   bus   sqrt_job_controller_if.slave: operand handshake, core launch/result,
//         result FIFO head, busy flag
// Parameters:
//   DATA_W   operand width (even, >= 4); root width is DATA_W/2
//   TIMEOUT  maximum WAIT cycles per job (1..255)
// -----------------------------------------------------------------------------
module sqrt_job_controller
    import sqrt_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    sqrt_job_controller_if.slave  bus
);

    localparam int                ROOT_W    = DATA_W / 2;
    localparam int                ENTRY_W   = ROOT_W + 1 + CYC_W;
    localparam logic [CYC_W-1:0]  TIMEOUT_C = CYC_W'(TIMEOUT);

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    operand_q, operand_d;
    logic [CYC_W-1:0]     cnt_q, cnt_d;
    logic [ROOT_W-1:0]    root_q, root_d;
    logic                 err_q, err_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;

    logic                 in_ready;
    logic                 accept;
    logic                 fifo_push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [1:0]           fifo_count;
    logic [ENTRY_W-1:0]   fifo_head;

    // Readiness depends only on registered state, never on out_ready_i; it is
    // held low while rst is asserted so the reset cycle shows all outputs 0.
    assign in_ready = !rst && (state_q == ST_IDLE) && (fifo_count < 2'd2);
    assign accept   = bus.in_valid_i && in_ready;

    // NOTE: every *_d gets its hold value before the case statement, so no
    // path through the block leaves a variable unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        cnt_d     = cnt_q;
        root_d    = root_q;
        err_d     = err_q;
        cyc_d     = cyc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    operand_d = bus.in_data_i;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = CYC_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done pulse in the timeout cycle still wins over the timeout.
                if (bus.core_done_i) begin
                    root_d  = bus.core_root_i;
                    err_d   = 1'b0;
                    cyc_d   = cnt_q;
                    state_d = ST_STORE;
                end else if (cnt_q == TIMEOUT_C) begin
                    root_d  = '0;
                    err_d   = 1'b1;
                    cyc_d   = TIMEOUT_C;
                    state_d = ST_STORE;
                end else begin
                    cnt_d = cnt_q + CYC_W'(1);
                end
            end
            ST_STORE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            operand_q <= '0;
            cnt_q     <= '0;
            root_q    <= '0;
            err_q     <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            cnt_q     <= cnt_d;
            root_q    <= root_d;
            err_q     <= err_d;
            cyc_q     <= cyc_d;
        end
    end

    // Acceptance only happens with a free slot, so the full gate never blocks
    // a real push; it only keeps the FIFO safe against misuse.
    assign fifo_push = (state_q == ST_STORE) && !fifo_full;

    sqrt_result_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i ({root_q, err_q, cyc_q}),
        .pop_i       (bus.out_ready_i),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign bus.in_ready_o     = in_ready;
    assign bus.core_start_o   = (state_q == ST_LAUNCH);
    assign bus.core_operand_o = operand_q;
    assign bus.busy_o         = (state_q != ST_IDLE);
    assign bus.out_valid_o    = !fifo_empty;
    assign bus.out_root_o     = fifo_head[ENTRY_W-1 -: ROOT_W];
    assign bus.out_err_o      = fifo_head[CYC_W];
    assign bus.out_cycles_o   = fifo_head[CYC_W-1:0];

endmodule

// File: tb/tb_sqrt_job_controller.sv
// -----------------------------------------------------------------------------
// tb_sqrt_job_controller
// Self-checking bench for sqrt_job_controller (DATA_W = 8, TIMEOUT = 10).
// A behavioural core answers each launch after a per-job delay (0 = never);
// expected results come from an integer square root and the timeout rule.
// -----------------------------------------------------------------------------
module tb_sqrt_job_controller;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 10;

    typedef struct {
        logic [7:0] op;
        int         delay;
        logic [3:0] root;
        logic       err;
        logic [7:0] cyc;
        int         lat;
    } vec_t;

    typedef struct {
        logic [3:0] root;
        logic       err;
        logic [7:0] cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Core model bookkeeping: the main process writes delay_arr/del_wr and
    // inject_req; the core process owns del_rd and inject_ack.
    int unsigned delay_arr [1024];
    int          del_wr     = 0;
    int          del_rd     = 0;
    int          inject_req = 0;
    int          inject_ack = 0;
    bit          cm_active  = 1'b0;
    int          cm_wait    = 0;
    int          cm_delay   = 0;
    logic [7:0]  cm_op      = '0;

    res_t exp_q [$];
    vec_t vecs  [7];

    sqrt_job_controller_if #(.DATA_W(DATA_W)) bus ();

    sqrt_job_controller #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int unsigned isqrt(input int unsigned x);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic res_t model(input logic [7:0] op, input int d);
        res_t r;
        if (d >= 1 && d <= TIMEOUT) begin
            r.root = 4'(isqrt(32'(op)));
            r.err  = 1'b0;
            r.cyc  = 8'(d);
        end else begin
            r.root = 4'd0;
            r.err  = 1'b1;
            r.cyc  = 8'(TIMEOUT);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Behavioural square-root core, acting 2 time units after each edge.
    always begin
        @(posedge clk);
        #2;
        bus.core_done_i = 1'b0;
        bus.core_root_i = 4'd0;
        if (rst) begin
            cm_active = 1'b0;
        end else begin
            if (inject_req != inject_ack) begin
                bus.core_done_i = 1'b1;
                bus.core_root_i = 4'd15;
                inject_ack      = inject_req;
            end
            if (cm_active) begin
                cm_wait++;
                if (cm_wait == cm_delay) begin
                    bus.core_done_i = 1'b1;
                    bus.core_root_i = 4'(isqrt(32'(cm_op)));
                    cm_active       = 1'b0;
                end else if (cm_wait >= TIMEOUT) begin
                    cm_active = 1'b0;
                end
            end
            if (bus.core_start_o) begin
                cm_active = 1'b1;
                cm_wait   = 0;
                cm_op     = bus.core_operand_o;
                cm_delay  = (del_rd < del_wr) ? int'(delay_arr[del_rd]) : 0;
                del_rd++;
            end
        end
    end

    // Offers op until accepted; returns 1 time unit into the cycle after the
    // accepting edge (the LAUNCH cycle) with in_valid_i dropped.
    task automatic offer(input logic [7:0] op, input bit inject);
        bit ok = 1'b0;
        next_cycle();
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = op;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                ok = 1'b1;
                if (inject) inject_req++;
                break;
            end
            next_cycle();
        end
        next_cycle();
        bus.in_valid_i = 1'b0;
        check("offer_accepted", 32'(ok), 32'd1);
    endtask

    // Checks the launch cycle, then waits for the result and checks it.
    task automatic expect_job(input string tag, input logic [7:0] op, input logic [3:0] root,
                              input logic err, input logic [7:0] cyc, input int lat);
        int n;
        @(negedge clk);
        check({tag, "_start"}, 32'(bus.core_start_o), 32'd1);
        check({tag, "_operand"}, 32'(bus.core_operand_o), 32'(op));
        n = 1;
        while (!bus.out_valid_o && n < 400) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_root"}, 32'(bus.out_root_o), 32'(root));
        check({tag, "_err"}, 32'(bus.out_err_o), 32'(err));
        check({tag, "_cycles"}, 32'(bus.out_cycles_o), 32'(cyc));
    endtask

    task automatic pop_head();
        next_cycle();
        bus.out_ready_i = 1'b1;
        next_cycle();
        bus.out_ready_i = 1'b0;
    endtask

    task automatic sample_pop();
        res_t e;
        if (bus.out_valid_o && bus.out_ready_i) begin
            check("rand_expect_available", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rand_root", 32'(bus.out_root_o), 32'(e.root));
                check("rand_err", 32'(bus.out_err_o), 32'(e.err));
                check("rand_cycles", 32'(bus.out_cycles_o), 32'(e.cyc));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        bus.core_done_i = 1'b0;
        bus.core_root_i = '0;

        vecs[0] = '{8'd49,  5,  4'd7,  1'b0, 8'd5,  8};
        vecs[1] = '{8'd0,   1,  4'd0,  1'b0, 8'd1,  4};
        vecs[2] = '{8'd255, 3,  4'd15, 1'b0, 8'd3,  6};
        vecs[3] = '{8'd1,   10, 4'd1,  1'b0, 8'd10, 13};
        vecs[4] = '{8'd100, 0,  4'd0,  1'b1, 8'd10, 13};
        vecs[5] = '{8'd200, 11, 4'd0,  1'b1, 8'd10, 13};
        vecs[6] = '{8'd15,  2,  4'd3,  1'b0, 8'd2,  5};

        // Reset state (rst still high after one reset edge).
        next_cycle();
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_start", 32'(bus.core_start_o), 32'd0);
        check("rst_operand", 32'(bus.core_operand_o), 32'd0);
        check("rst_out_data", 32'({bus.out_root_o, bus.out_err_o, bus.out_cycles_o}), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_in_ready", 32'(bus.in_ready_o), 32'd1);

        // Table-driven single jobs, including timeout and the 49 -> 7 case.
        for (int i = 0; i < 7; i++) begin
            delay_arr[del_wr] = vecs[i].delay;
            del_wr++;
            offer(vecs[i].op, 1'b0);
            expect_job("vec", vecs[i].op, vecs[i].root, vecs[i].err, vecs[i].cyc, vecs[i].lat);
            pop_head();
            @(negedge clk);
            check("vec_popped_empty", 32'(bus.out_valid_o), 32'd0);
            check("vec_empty_data", 32'({bus.out_root_o, bus.out_err_o, bus.out_cycles_o}), 32'd0);
        end

        // Done pulses in IDLE and LAUNCH are ignored.
        @(negedge clk);
        inject_req++;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("idle_done_ignored", 32'(bus.out_valid_o | bus.busy_o), 32'd0);
        delay_arr[del_wr] = 4;
        del_wr++;
        offer(8'd49, 1'b1);
        expect_job("launch_done", 8'd49, 4'd7, 1'b0, 8'd4, 7);
        pop_head();

        // Back-pressure: 16 and 25 fill the FIFO, 36 waits for a pop.
        for (int i = 0; i < 3; i++) begin
            delay_arr[del_wr] = 2;
            del_wr++;
        end
        offer(8'd16, 1'b0);
        offer(8'd25, 1'b0);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'd36;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) seen++;
            next_cycle();
        end
        check("full_blocks_input", 32'(seen), 32'd0);
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        check("pop_no_comb_ready", 32'(bus.in_ready_o), 32'd0);
        check("full_head_root", 32'(bus.out_root_o), 32'd4);
        next_cycle();
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        check("ready_after_pop", 32'(bus.in_ready_o), 32'd1);
        check("second_head_root", 32'(bus.out_root_o), 32'd5);
        next_cycle();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        next_cycle();
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid_o) break;
            next_cycle();
        end
        check("third_head_root", 32'(bus.out_root_o), 32'd6);
        pop_head();

        // Push and pop in the same cycle with one entry held.
        delay_arr[del_wr] = 1;
        del_wr++;
        offer(8'd100, 1'b0);
        expect_job("hold_a", 8'd100, 4'd10, 1'b0, 8'd1, 4);
        delay_arr[del_wr] = 3;
        del_wr++;
        offer(8'd144, 1'b0);
        for (int i = 0; i < 4; i++) next_cycle();
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        check("pushpop_busy", 32'(bus.busy_o), 32'd1);
        check("pushpop_old_head", 32'(bus.out_root_o), 32'd10);
        next_cycle();
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        check("pushpop_new_valid", 32'(bus.out_valid_o), 32'd1);
        check("pushpop_new_root", 32'(bus.out_root_o), 32'd12);
        check("pushpop_new_cycles", 32'(bus.out_cycles_o), 32'd3);
        pop_head();
        @(negedge clk);
        check("pushpop_count_one", 32'(bus.out_valid_o), 32'd0);

        // Reset during WAIT with a result already queued.
        delay_arr[del_wr] = 2;
        del_wr++;
        offer(8'd9, 1'b0);
        expect_job("pre_rst", 8'd9, 4'd3, 1'b0, 8'd2, 5);
        delay_arr[del_wr] = 0;
        del_wr++;
        offer(8'd64, 1'b0);
        for (int i = 0; i < 3; i++) next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check("wait_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("wait_rst_busy", 32'(bus.busy_o), 32'd0);
        check("wait_rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        check("wait_rst_operand", 32'(bus.core_operand_o), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("wait_rst_release_ready", 32'(bus.in_ready_o), 32'd1);
        inject_req++;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            next_cycle();
            @(negedge clk);
            if (bus.out_valid_o || bus.busy_o) seen++;
        end
        check("spurious_done_after_rst", 32'(seen), 32'd0);

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 600; c++) begin
            int d;
            next_cycle();
            bus.in_valid_i  = 1'($urandom_range(0, 1));
            bus.in_data_i   = 8'($urandom);
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_valid_i && bus.in_ready_o) begin
                d = int'($urandom_range(0, 12));
                delay_arr[del_wr] = d;
                del_wr++;
                exp_q.push_back(model(bus.in_data_i, d));
            end
            sample_pop();
            if (bus.busy_o && bus.in_ready_o) begin
                check("rand_ready_while_busy", 32'(bus.in_ready_o), 32'd0);
            end
            if (!bus.out_valid_o && ({bus.out_root_o, bus.out_err_o, bus.out_cycles_o} != '0)) begin
                check("rand_empty_data", 32'({bus.out_root_o, bus.out_err_o, bus.out_cycles_o}), 32'd0);
            end
            if (bus.core_start_o && bus.in_ready_o) begin
                check("rand_start_while_ready", 32'(bus.core_start_o), 32'd0);
            end
        end

        // Drain.
        next_cycle();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            sample_pop();
            if (exp_q.size() == 0 && !bus.busy_o && !bus.out_valid_o) break;
            next_cycle();
        end
        check("rand_scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("rand_final_out_valid", 32'(bus.out_valid_o), 32'd0);
        next_cycle();
        bus.out_ready_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sqrt_job_controller.md
SQRT_JOB_CONTROLLER -- requirements
Module: sqrt_job_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width; even, >= 4; root width ROOT_W = DATA_W/2.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles per job; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising clk edge.
REQ-005 in_valid_i  input  1  operand offered.
REQ-006 in_ready_o  output  1  operand can be accepted this cycle.
REQ-007 in_data_i  input  DATA_W  unsigned operand.
REQ-008 core_start_o  output  1  one-cycle pulse that launches the square-root core.
REQ-009 core_operand_o  output  DATA_W  operand for the core; held stable until the next acceptance.
REQ-010 core_done_i  input  1  core result valid (single-cycle pulse).
REQ-011 core_root_i  input  ROOT_W  core result.
REQ-012 out_valid_o  output  1  result FIFO not empty.
REQ-013 out_ready_i  input  1  consumer takes the head entry.
REQ-014 out_root_o  output  ROOT_W  head root.
REQ-015 out_err_o  output  1  head entry ended by timeout.
REQ-016 out_cycles_o  output  8  head entry WAIT-cycle count.
REQ-017 busy_o  output  1  state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, LAUNCH, WAIT and STORE.
REQ-019 IDLE: in_ready_o = 1 iff registered FIFO count < 2; in_valid_i & in_ready_o latches in_data_i into core_operand_o and moves to LAUNCH.
REQ-020 LAUNCH: core_start_o = 1 for exactly this cycle; cycle counter loads 1; next state is WAIT.
REQ-021 WAIT: if core_done_i, capture core_root_i, err = 0 and the counter, then go to STORE.
REQ-022 WAIT, no done: if counter == TIMEOUT, capture root = 0, err = 1 and counter = TIMEOUT, then go to STORE; otherwise increment the counter.
REQ-023 STORE: push {root, err, cycles} into the FIFO; next state is IDLE; the pushed entry is visible on out_* in the next cycle.
REQ-024 Per-job latency: accept at cycle t, start pulse at t+1, first WAIT at t+2, STORE the cycle after done, out_valid_o the cycle after that.
REQ-025 in_ready_o SHALL be 0 in LAUNCH, WAIT and STORE (one job in flight).
REQ-026 in_ready_o SHALL have no combinational path from out_ready_i.
REQ-027 core_done_i outside WAIT SHALL be ignored.
REQ-028 core_start_o SHALL never be asserted outside LAUNCH.
REQ-029 Operand 0 SHALL be launched normally, with no shortcut.
REQ-030 FIFO: 2 entries, first in first out; pop on out_valid_o & out_ready_i.
REQ-031 A simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-032 out_ready_i while empty SHALL have no effect; a push is never attempted when full, because acceptance in REQ-019 guarantees space.
REQ-033 out_* data outputs SHALL be 0 when the FIFO is empty.

Reset
REQ-034 On rst: state IDLE, FIFO empty, counter 0, core_operand_o 0; all outputs 0, except in_ready_o, which is 1 in the first cycle after rst deasserts.
REQ-035 rst in any state SHALL abandon the in-flight job without producing a result; FIFO contents are discarded.

Structure
REQ-036 Package sqrt_pkg SHALL hold the state encoding (IDLE 00, LAUNCH 01, WAIT 11, STORE 10, Gray), CYC_W = 8 and default DATA_W/TIMEOUT constants.
REQ-037 The FIFO SHALL be sub-module sqrt_result_fifo, depth 2, width ROOT_W+1+CYC_W, with push/pop/full/empty/count ports.

Verification
REQ-038 Operand 49; core model pulses done with root 7 on the 5th WAIT cycle -> start pulse 1 cycle after accept; out_root_o 7, out_err_o 0, out_cycles_o 5.
REQ-039 out_ready_i held 0; operands 16, 25 and 36 offered back-to-back (roots 4, 5, 6) -> two accepted; in_ready_o 0 once count = 2. Then out_ready_i pulsed once -> 4 popped, 36 accepted the next cycle; FIFO order 5 then 6.
REQ-040 TIMEOUT=10; core never responds -> STORE after the 10th WAIT cycle; out_root_o 0, out_err_o 1, out_cycles_o 10.
REQ-041 rst asserted during WAIT; spurious core_done_i pulse after reset -> out_valid_o stays 0; in_ready_o 1 in the first cycle after deassert.
REQ-042 FIFO holds 1 entry; STORE coincides with pop -> count stays 1; the new entry appears at the head the next cycle.
REQ-043 core_done_i pulsed in IDLE and LAUNCH -> ignored; job completes only on the WAIT-state done.
